// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad row scanner with frame debounce and single-key press detection
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000000,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_multi
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } key_class_t;

  localparam logic [31:0] DIV_MAX = 32'(SCAN_DIV - 1);
  localparam logic [3:0]  CNT_MAX = 4'(DEB_FRAMES - 1);

  logic [2:0]  col_meta;
  logic [2:0]  col_sync;
  logic [31:0] div;
  logic [1:0]  row_idx;
  logic [11:0] frame;
  logic [11:0] cand;
  logic [11:0] stable;
  logic [3:0]  cnt;
  key_class_t  state;

  logic        tick;
  logic [11:0] frame_next;
  logic [11:0] cand_next;
  logic [3:0]  cnt_next;
  key_class_t  stable_class;
  logic [3:0]  stable_code;

  assign tick = (div == DIV_MAX);

  always_comb begin
    frame_next = frame;
    case (row_idx)
      2'd0:    frame_next[2:0]  = col_sync;
      2'd1:    frame_next[5:3]  = col_sync;
      2'd2:    frame_next[8:6]  = col_sync;
      default: frame_next[11:9] = col_sync;
    endcase
  end

  // Only consumed on the tick that closes a frame (row index 3).
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (frame_next == cand) begin
      if (cnt != CNT_MAX) cnt_next = cnt + 4'd1;
    end else begin
      cand_next = frame_next;
      cnt_next  = 4'd0;
    end
  end

  always_comb begin
    if (stable == 12'd0)
      stable_class = IDLE;
    else if ((stable & (stable - 12'd1)) == 12'd0)
      stable_class = SINGLE;
    else
      stable_class = MULTI;
  end

  // Bit index is row*3+col; rows 0-2 hold digits 1-9, row 3 holds *, 0, #.
  always_comb begin
    stable_code = 4'h0;
    for (int i = 0; i < 12; i++) begin
      if (stable[i]) begin
        if (i < 9)        stable_code = 4'(i + 1);
        else if (i == 9)  stable_code = 4'hA;
        else if (i == 10) stable_code = 4'h0;
        else              stable_code = 4'hB;
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      col_meta  <= 3'd0;
      col_sync  <= 3'd0;
      div       <= 32'd0;
      row_idx   <= 2'd0;
      row       <= 4'b0001;
      frame     <= 12'd0;
      cand      <= 12'd0;
      stable    <= 12'd0;
      cnt       <= 4'd0;
      state     <= IDLE;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_multi <= 1'b0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
      div      <= tick ? 32'd0 : div + 32'd1;
      if (tick) begin
        frame   <= frame_next;
        row_idx <= row_idx + 2'd1;
        row     <= {row[2:0], row[3]};
        if (row_idx == 2'd3) begin
          cand <= cand_next;
          cnt  <= cnt_next;
          if (cnt_next == CNT_MAX) stable <= cand_next;
        end
      end
      // state trails stable_class by one cycle, so IDLE->SINGLE is seen exactly once.
      state     <= stable_class;
      key_valid <= (stable_class == SINGLE) && (state == IDLE);
      if ((stable_class == SINGLE) && (state == IDLE)) key_code <= stable_code;
      key_down  <= (stable_class == SINGLE);
      key_multi <= (stable_class == MULTI);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - frame-level reference model bench for keypad_scanner
module tb_keypad_scanner;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_FRAMES = 3;
  localparam int FRAME      = 4 * SCAN_DIV;
  localparam int LATENCY    = (DEB_FRAMES + 1) * FRAME + 4;

  logic       clk = 1'b0;
  logic       init_n;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       key_multi;
  logic [11:0] keys = 12'd0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .clk(clk), .init_n(init_n), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .key_multi(key_multi)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row line onto its column line.
  always_comb begin
    col = 3'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (row[r] && keys[r * 3 + c]) col[c] = 1'b1;
  end

  int compared = 0;
  int mismatched = 0;
  int e, run, pulses, last_pulse_e, p0;
  logic [11:0] last_frame, m_new, m_cur;
  logic [3:0]  exp_code;
  logic        exp_valid, exp_down, exp_multi, prev_valid;
  int code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  function automatic logic [11:0] k(input int i);
    logic [11:0] one;
    one = 12'd1;
    k = one << i;
  endfunction

  function automatic logic [3:0] code_of(input logic [11:0] m);
    code_of = 4'h0;
    for (int i = 0; i < 12; i++)
      if (m[i]) code_of = 4'(code_tab[i]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; run = 1; last_frame = 12'd0; m_new = 12'd0; m_cur = 12'd0;
    exp_code = 4'h0; exp_valid = 1'b0; exp_down = 1'b0; exp_multi = 1'b0;
    prev_valid = 1'b0;
  endtask

  task automatic step();
    logic [3:0] exp_row;
    @(posedge clk);
    e++;
    if (e % FRAME == 0) begin
      if (keys == last_frame) run++;
      else begin last_frame = keys; run = 1; end
      if (run >= DEB_FRAMES) m_new = last_frame;
    end
    if (e % FRAME == 1) begin
      exp_valid = ($countones(m_new) == 1) && (m_cur == 12'd0);
      if (exp_valid) exp_code = code_of(m_new);
      exp_down  = ($countones(m_new) == 1);
      exp_multi = ($countones(m_new) >= 2);
      m_cur = m_new;
    end else begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    exp_row = 4'b0001 << ((e / SCAN_DIV) % 4);
    check("row", row, exp_row);
    check("key_valid", key_valid, exp_valid);
    check("key_code", key_code, exp_code);
    check("key_down", key_down, exp_down);
    check("key_multi", key_multi, exp_multi);
    if (prev_valid) check("valid_twice", key_valid, 1'b0);
    if (key_valid) begin pulses++; last_pulse_e = e; end
    prev_valid = key_valid;
  endtask

  task automatic run_frames(input logic [11:0] mask, input int n);
    keys = mask;
    repeat (n * FRAME) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_row"}, row, 4'b0001);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_down"}, key_down, 1'b0);
    check({tag, "_multi"}, key_multi, 1'b0);
  endtask

  initial begin
    logic [11:0] mask;
    int len;
    pulses = 0; last_pulse_e = 0;
    init_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    init_n = 1'b1;

    run_frames(12'd0, 2);
    p0 = pulses;
    run_frames(k(4), 5);
    check("five_pulses", pulses - p0, 1);
    check("five_code", key_code, 4'h5);
    check("five_down", key_down, 1'b1);
    run_frames(12'd0, 4);
    check("five_release", key_down, 1'b0);
    check("five_no_repeat", pulses - p0, 1);

    p0 = pulses;
    run_frames(k(9), 4);
    check("star_code", key_code, 4'hA);
    run_frames(12'd0, 4);
    run_frames(k(11), 4);
    check("hash_code", key_code, 4'hB);
    run_frames(12'd0, 4);
    run_frames(k(10), 4);
    check("zero_code", key_code, 4'h0);
    run_frames(12'd0, 4);
    check("three_pulses", pulses - p0, 3);

    p0 = pulses;
    for (int i = 0; i < 10; i++) run_frames((i % 2 == 0) ? k(7) : 12'd0, 1);
    check("bounce_no_pulse", pulses - p0, 0);
    run_frames(k(7), 4);
    check("eight_pulse", pulses - p0, 1);
    check("eight_code", key_code, 4'h8);
    run_frames(12'd0, 4);

    p0 = pulses;
    run_frames(k(0) | k(8), 4);
    check("multi_level", key_multi, 1'b1);
    check("multi_down", key_down, 1'b0);
    run_frames(k(0), 4);
    check("multi_to_single_multi", key_multi, 1'b0);
    check("multi_to_single_down", key_down, 1'b1);
    check("multi_no_pulse", pulses - p0, 0);
    run_frames(12'd0, 4);

    p0 = pulses;
    run_frames(k(2), 4);
    check("three_accept", pulses - p0, 1);
    repeat (5) step();
    init_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(posedge clk); @(negedge clk);
    check_reset_state("midreset_hold");
    @(posedge clk); @(negedge clk);
    init_n = 1'b1;
    model_reset();
    p0 = pulses;
    last_pulse_e = LATENCY + 1;
    run_frames(k(2), 5);
    check("reaccept_pulse", pulses - p0, 1);
    check("reaccept_latency", last_pulse_e <= LATENCY, 1'b1);
    check("reaccept_code", key_code, 4'h3);
    run_frames(12'd0, 4);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       mask = 12'd0;
        1, 2:    mask = k($urandom_range(0, 11));
        default: mask = k($urandom_range(0, 11)) | k($urandom_range(0, 11));
      endcase
      len = $urandom_range(1, 4);
      run_frames(mask, len);
    end
    run_frames(12'd0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
